// File: rtl/univ_shift_reg_gen.sv
// Parametrised universal shift register with a counted burst-shift mode (busy/done handshake).
// Optional rotate support is compiled in when USR_ROTATE_EN is defined.
module univ_shift_reg_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic             rot,
  input  logic             left_in,
  input  logic             right_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             left_out,
  output logic             right_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] remaining_q;
  logic             dir_left_q;
  logic             busy_q;
  logic             done_q;

  logic             rsh_in;
  logic             lsh_in;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;
  logic             accept;

`ifdef USR_ROTATE_EN
  logic rot_q;
  logic rot_eff;

  // A running burst uses the rot value captured at accept, not the live input.
  assign rot_eff = (state_q == StBusy) ? rot_q : rot;
  assign rsh_in  = rot_eff ? out_q[0] : right_in;
  assign lsh_in  = rot_eff ? out_q[WIDTH-1] : left_in;
`else
  logic unused_rot;

  assign unused_rot = rot;
  assign rsh_in     = right_in;
  assign lsh_in     = left_in;
`endif

  always_comb begin
    shr_val = {rsh_in, out_q[WIDTH-1:1]};
    shl_val = {out_q[WIDTH-2:0], lsh_in};
  end

  assign accept = start && (count != '0) && ((sel == 2'b01) || (sel == 2'b10));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      out_q       <= '0;
      remaining_q <= '0;
      dir_left_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef USR_ROTATE_EN
      rot_q       <= 1'b0;
`endif
    end else if (en) begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            dir_left_q  <= sel[1];
            remaining_q <= count;
            busy_q      <= 1'b1;
            state_q     <= StBusy;
`ifdef USR_ROTATE_EN
            rot_q       <= rot;
`endif
          end else begin
            unique case (sel)
              2'b01:   out_q <= shr_val;
              2'b10:   out_q <= shl_val;
              2'b11:   out_q <= data_in;
              default: out_q <= out_q;
            endcase
          end
        end
        StBusy: begin
          out_q       <= dir_left_q ? shl_val : shr_val;
          remaining_q <= remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out       = out_q;
  assign left_out  = out_q[WIDTH-1];
  assign right_out = out_q[0];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
